// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: requester ids and the
// registered controller command.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 26;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        logic [SDRAM_DATA_W-1:0] writedata;
        logic [1:0]              byteenable_n;
        logic                    read_n;
        logic                    write_n;
    } sdram_cmd_t;

    localparam sdram_cmd_t CMD_IDLE = '{
        addr:         '0,
        writedata:    '0,
        byteenable_n: 2'b11,
        read_n:       1'b1,
        write_n:      1'b1
    };

endpackage

// File: rtl/sdram_tag_fifo.sv
// Records which requester issued each outstanding read, in issue order,
// so returning read data can be steered back to its owner.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  req_id_t          push_id_i,
    input  logic             pop_i,
    output req_id_t          head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    req_id_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer wrap relies on DEPTH being a power of two.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !full_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller: port A
// (waveform fetch) has priority, port B (host loader) is protected from starvation.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int STARVE_LIMIT    = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1,
    localparam int STARVE_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                    clock,
    input  logic                    reset_n,

    input  logic [SDRAM_ADDR_W-1:0] a_address,
    input  logic                    a_read,
    input  logic                    a_write,
    input  logic [SDRAM_DATA_W-1:0] a_writedata,
    input  logic [1:0]              a_byteenable,
    output logic                    a_waitrequest,
    output logic [SDRAM_DATA_W-1:0] a_readdata,
    output logic                    a_readdata_valid,

    input  logic [SDRAM_ADDR_W-1:0] b_address,
    input  logic                    b_read,
    input  logic                    b_write,
    input  logic [SDRAM_DATA_W-1:0] b_writedata,
    input  logic [1:0]              b_byteenable,
    output logic                    b_waitrequest,
    output logic [SDRAM_DATA_W-1:0] b_readdata,
    output logic                    b_readdata_valid,

    output logic [SDRAM_ADDR_W-1:0] sdram_addr,
    output logic [1:0]              sdram_byteenable_n,
    output logic                    sdram_chipselect,
    output logic [SDRAM_DATA_W-1:0] sdram_writedata,
    output logic                    sdram_read_n,
    output logic                    sdram_write_n,
    input  logic [SDRAM_DATA_W-1:0] sdram_readdata,
    input  logic                    sdram_readdata_valid,
    input  logic                    sdram_waitrequest,

    output logic [CNT_W-1:0]        outstanding,
    output logic                    protocol_error
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    sdram_cmd_t          cmd_q, cmd_d;
    logic                cs_q, cs_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                perr_q, perr_d;

    logic    a_req, b_req;
    logic    grant_b;
    logic    win_rd, win_wr;
    logic    reg_free;
    logic    capture;
    req_id_t fifo_head;
    logic    fifo_empty, fifo_full;

    assign a_req = a_read | a_write;
    assign b_req = b_read | b_write;

    // Read+write together is illegal and is executed as a read.
    assign grant_b  = b_req && (!a_req || (starve_q == STARVE_MAX));
    assign win_rd   = grant_b ? b_read : a_read;
    assign win_wr   = grant_b ? (b_write & ~b_read) : (a_write & ~a_read);
    assign reg_free = !cs_q || !sdram_waitrequest;

    // Full is the pre-pop state, so a read never slips in on a pop cycle.
    assign capture = reset_n && reg_free && (a_req || b_req) && (win_wr || !fifo_full);

    assign a_waitrequest = !(capture && !grant_b);
    assign b_waitrequest = !(capture && grant_b);

    always_comb begin
        cmd_d = cmd_q;
        cs_d  = cs_q;
        if (capture) begin
            cs_d               = 1'b1;
            cmd_d.addr         = grant_b ? b_address : a_address;
            cmd_d.writedata    = grant_b ? b_writedata : a_writedata;
            cmd_d.byteenable_n = grant_b ? ~b_byteenable : ~a_byteenable;
            cmd_d.read_n       = ~win_rd;
            cmd_d.write_n      = ~win_wr;
        end else if (reg_free) begin
            cs_d          = 1'b0;
            cmd_d.read_n  = 1'b1;
            cmd_d.write_n = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!b_req || (capture && grant_b)) begin
            starve_d = '0;
        end else if (capture && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign perr_d = perr_q
                  | (a_read & a_write)
                  | (b_read & b_write)
                  | (sdram_readdata_valid & fifo_empty);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cmd_q    <= CMD_IDLE;
            cs_q     <= 1'b0;
            starve_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            cmd_q    <= cmd_d;
            cs_q     <= cs_d;
            starve_q <= starve_d;
            perr_q   <= perr_d;
        end
    end

    sdram_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_i    (capture && win_rd),
        .push_id_i (grant_b ? REQ_B : REQ_A),
        .pop_i     (sdram_readdata_valid),
        .head_o    (fifo_head),
        .count_o   (outstanding),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign a_readdata       = sdram_readdata;
    assign b_readdata       = sdram_readdata;
    assign a_readdata_valid = sdram_readdata_valid && !fifo_empty && (fifo_head == REQ_A);
    assign b_readdata_valid = sdram_readdata_valid && !fifo_empty && (fifo_head == REQ_B);

    assign sdram_addr         = cmd_q.addr;
    assign sdram_writedata    = cmd_q.writedata;
    assign sdram_byteenable_n = cmd_q.byteenable_n;
    assign sdram_read_n       = cmd_q.read_n;
    assign sdram_write_n      = cmd_q.write_n;
    assign sdram_chipselect   = cs_q;
    assign protocol_error     = perr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised and directed bench for sdram_arbiter with a transaction-level
// reference model, a scoreboard monitor and a simple SDRAM controller model.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int MAXO  = 4;
    localparam int LIM   = 8;
    localparam int CNT_W = $clog2(MAXO) + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [25:0] a_address, b_address;
    logic        a_read, a_write, b_read, b_write;
    logic [15:0] a_writedata, b_writedata;
    logic [1:0]  a_byteenable, b_byteenable;
    logic        a_waitrequest, b_waitrequest;
    logic [15:0] a_readdata, b_readdata;
    logic        a_readdata_valid, b_readdata_valid;
    logic [25:0] sdram_addr;
    logic [1:0]  sdram_byteenable_n;
    logic        sdram_chipselect, sdram_read_n, sdram_write_n;
    logic [15:0] sdram_writedata, sdram_readdata;
    logic        sdram_readdata_valid, sdram_waitrequest;
    logic [CNT_W-1:0] outstanding;
    logic        protocol_error;

    sdram_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_byteenable(a_byteenable),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdata_valid(a_readdata_valid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_byteenable(b_byteenable),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdata_valid(b_readdata_valid),
        .sdram_addr(sdram_addr), .sdram_byteenable_n(sdram_byteenable_n),
        .sdram_chipselect(sdram_chipselect), .sdram_writedata(sdram_writedata),
        .sdram_read_n(sdram_read_n), .sdram_write_n(sdram_write_n),
        .sdram_readdata(sdram_readdata), .sdram_readdata_valid(sdram_readdata_valid),
        .sdram_waitrequest(sdram_waitrequest),
        .outstanding(outstanding), .protocol_error(protocol_error)
    );

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [25:0] addr;
        logic [15:0] wd;
        logic [1:0]  be;
    } preq_t;

    typedef struct packed {
        logic [25:0] addr;
        logic [15:0] wd;
        logic [1:0]  be_n;
        logic        rd_n;
        logic        wr_n;
    } cmd_e_t;

    typedef struct packed {
        logic        port_b;
        logic [15:0] data;
    } ret_t;

    int n_cmp = 0;
    int n_bad = 0;

    preq_t  pa, pb;
    cmd_e_t cmd_q[$];
    ret_t   ret_q[$];
    logic [15:0] ctrl_q[$];

    // Reference model state
    bit m_pend;
    int m_cnt;
    int m_starve;
    bit m_perr;

    int req_pct, rd_pct, wait_pct, ret_pct;
    bit force_rdv;
    int grants_a, grants_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] rdata(input logic [25:0] addr);
        return addr[15:0] ^ 16'h5A3C ^ {6'd0, addr[25:16]};
    endfunction

    function automatic preq_t new_req(input int pct_rd);
        preq_t r;
        r.rd   = ($urandom_range(99) < 32'(pct_rd));
        r.wr   = !r.rd;
        r.addr = 26'($urandom);
        r.wd   = 16'($urandom);
        r.be   = 2'($urandom);
        return r;
    endfunction

    task automatic drive();
        if (!pa.rd && !pa.wr && ($urandom_range(99) < 32'(req_pct))) pa = new_req(rd_pct);
        if (!pb.rd && !pb.wr && ($urandom_range(99) < 32'(req_pct))) pb = new_req(rd_pct);
        a_read = pa.rd; a_write = pa.wr; a_address = pa.addr; a_writedata = pa.wd; a_byteenable = pa.be;
        b_read = pb.rd; b_write = pb.wr; b_address = pb.addr; b_writedata = pb.wd; b_byteenable = pb.be;
        sdram_readdata = 16'($urandom);
        sdram_readdata_valid = 1'b0;
        if (!reset_n) begin
            sdram_waitrequest = 1'b1;
        end else begin
            sdram_waitrequest = ($urandom_range(99) < 32'(wait_pct));
            if (force_rdv) begin
                sdram_readdata_valid = 1'b1;
            end else if (ctrl_q.size() > 0 && ($urandom_range(99) < 32'(ret_pct))) begin
                sdram_readdata_valid = 1'b1;
                sdram_readdata = ctrl_q.pop_front();
            end
        end
    endtask

    // Predict this cycle's grant from the arbitration rules, then advance the model.
    task automatic step();
        bit areq, breq, bwin, wrd, free, cap;
        preq_t w;
        @(negedge clock);
        if (!reset_n) begin
            chk("rst_a_waitrequest", 32'(a_waitrequest), 32'd1);
            chk("rst_b_waitrequest", 32'(b_waitrequest), 32'd1);
            @(posedge clock);
            m_pend = 0; m_cnt = 0; m_starve = 0; m_perr = 0;
            cmd_q.delete(); ret_q.delete(); ctrl_q.delete();
            #1;
            return;
        end
        chk("outstanding", 32'(outstanding), 32'(m_cnt));
        chk("chipselect", 32'(sdram_chipselect), 32'(m_pend));
        chk("protocol_error", 32'(protocol_error), 32'(m_perr));
        areq = pa.rd | pa.wr;
        breq = pb.rd | pb.wr;
        bwin = breq && (!areq || m_starve == LIM);
        wrd  = bwin ? pb.rd : pa.rd;
        free = !m_pend || !sdram_waitrequest;
        cap  = free && (areq || breq) && (!wrd || m_cnt < MAXO);
        chk("a_waitrequest", 32'(a_waitrequest), 32'(!(cap && !bwin)));
        chk("b_waitrequest", 32'(b_waitrequest), 32'(!(cap && bwin)));
        if (areq && !a_waitrequest) grants_a++;
        if (breq && !b_waitrequest) grants_b++;
        if ((pa.rd && pa.wr) || (pb.rd && pb.wr)) m_perr = 1;
        if (sdram_readdata_valid && m_cnt == 0) m_perr = 1;
        if (!breq || (cap && bwin)) m_starve = 0;
        else if (cap && m_starve < LIM) m_starve++;
        if (sdram_readdata_valid && m_cnt > 0) m_cnt--;
        if (cap) begin
            w = bwin ? pb : pa;
            cmd_q.push_back(cmd_e_t'({w.addr, w.wd, ~w.be, ~w.rd, ~(w.wr & ~w.rd)}));
            if (w.rd) begin
                ret_q.push_back(ret_t'({bwin, rdata(w.addr)}));
                m_cnt++;
            end
            if (bwin) pb = '0;
            else pa = '0;
        end
        m_pend = cap ? 1'b1 : (free ? 1'b0 : m_pend);
        @(posedge clock);
        #1;
    endtask

    task automatic cycle();
        drive();
        step();
    endtask

    task automatic drain();
        req_pct = 0; force_rdv = 0; wait_pct = 0; ret_pct = 100;
        for (int i = 0; i < 300; i++) begin
            if (!(pa.rd | pa.wr | pb.rd | pb.wr) && m_cnt == 0 && !m_pend &&
                ret_q.size() == 0 && cmd_q.size() == 0 && ctrl_q.size() == 0) return;
            cycle();
        end
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: got cnt=%0d pending=%0d expected idle", m_cnt, m_pend);
    endtask

    // Scoreboard monitor: read returns and commands seen at the controller.
    initial begin
        ret_t   r;
        cmd_e_t c;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (a_readdata_valid || b_readdata_valid) begin
                    chk("dual_valid", 32'(a_readdata_valid && b_readdata_valid), 32'd0);
                    if (ret_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_valid: got a=%0d b=%0d expected none",
                                 a_readdata_valid, b_readdata_valid);
                    end else begin
                        r = ret_q.pop_front();
                        chk("ret_port", 32'(b_readdata_valid), 32'(r.port_b));
                        chk("ret_data", 32'(r.port_b ? b_readdata : a_readdata), 32'(r.data));
                    end
                end
                if (sdram_chipselect && !sdram_waitrequest) begin
                    if (cmd_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_cmd: got addr=%0h expected none", sdram_addr);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_addr", 32'(sdram_addr), 32'(c.addr));
                        chk("cmd_wdata", 32'(sdram_writedata), 32'(c.wd));
                        chk("cmd_be_n", 32'(sdram_byteenable_n), 32'(c.be_n));
                        chk("cmd_rw_n", 32'({sdram_read_n, sdram_write_n}), 32'({c.rd_n, c.wr_n}));
                    end
                    if (!sdram_read_n) ctrl_q.push_back(rdata(sdram_addr));
                end
            end
        end
    end

    initial begin
        pa = '0; pb = '0;
        req_pct = 0; rd_pct = 100; wait_pct = 0; ret_pct = 100; force_rdv = 0;
        m_pend = 0; m_cnt = 0; m_starve = 0; m_perr = 0;
        grants_a = 0; grants_b = 0;
        reset_n = 1'b0;
        drive();
        @(posedge clock);
        #1;
        pa.rd = 1'b1; pa.addr = 26'h3;
        cycle();
        cycle();
        reset_n = 1'b1;
        chk("reset_chipselect", 32'(sdram_chipselect), 32'd0);
        chk("reset_read_n", 32'(sdram_read_n), 32'd1);
        chk("reset_write_n", 32'(sdram_write_n), 32'd1);
        chk("reset_be_n", 32'(sdram_byteenable_n), 32'd3);
        chk("reset_addr", 32'(sdram_addr), 32'd0);
        chk("reset_wdata", 32'(sdram_writedata), 32'd0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_perr", 32'(protocol_error), 32'd0);
        drain();

        // Single A read to 0x10
        ret_pct = 0;
        pa = '0; pa.rd = 1'b1; pa.addr = 26'h10;
        cycle();
        chk("t1_addr", 32'(sdram_addr), 32'h10);
        chk("t1_read_n", 32'(sdram_read_n), 32'd0);
        cycle(); cycle();
        drain();
        chk("t1_outstanding", 32'(outstanding), 32'd0);

        // Both ports reading continuously: 8 A grants then 1 B grant
        req_pct = 100; rd_pct = 100; wait_pct = 0; ret_pct = 100;
        grants_a = 0; grants_b = 0;
        for (int i = 0; i < 100 && grants_b < 3; i++) cycle();
        chk("starve_a_grants", 32'(grants_a), 32'd24);
        chk("starve_b_grants", 32'(grants_b), 32'd3);
        drain();

        // B write held by controller stall for 5 cycles
        pb = '0; pb.wr = 1'b1; pb.addr = 26'h200; pb.wd = 16'h1234; pb.be = 2'b01;
        cycle();
        wait_pct = 100;
        pa = '0; pa.rd = 1'b1; pa.addr = 26'h77;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_addr", 32'(sdram_addr), 32'h200);
            chk("stall_wdata", 32'(sdram_writedata), 32'h1234);
            chk("stall_be_n", 32'(sdram_byteenable_n), 32'd2);
            chk("stall_write_n", 32'(sdram_write_n), 32'd0);
        end
        wait_pct = 0;
        drain();

        // Tag FIFO full: fifth read waits through the pop cycle
        ret_pct = 0;
        for (int i = 0; i < 4; i++) begin
            pa = '0; pa.rd = 1'b1; pa.addr = 26'(i + 32);
            cycle();
        end
        pa = '0; pa.rd = 1'b1; pa.addr = 26'h55;
        cycle(); cycle();
        chk("full_outstanding", 32'(outstanding), 32'd4);
        ret_pct = 100;
        cycle();
        cycle();
        drain();

        // Read data with no outstanding read
        force_rdv = 1'b1;
        cycle();
        force_rdv = 1'b0;
        cycle(); cycle();
        chk("orphan_perr", 32'(protocol_error), 32'd1);
        reset_n = 1'b0; cycle(); reset_n = 1'b1;
        chk("perr_cleared", 32'(protocol_error), 32'd0);

        // Illegal read+write executes as a read
        pa = '0; pa.rd = 1'b1; pa.wr = 1'b1; pa.addr = 26'h99;
        cycle();
        chk("illegal_read_n", 32'(sdram_read_n), 32'd0);
        chk("illegal_write_n", 32'(sdram_write_n), 32'd1);
        drain();
        reset_n = 1'b0; cycle(); reset_n = 1'b1;

        // Reset with two reads outstanding and one held
        ret_pct = 0; wait_pct = 0;
        pa = '0; pa.rd = 1'b1; pa.addr = 26'h1; cycle();
        pa = '0; pa.rd = 1'b1; pa.addr = 26'h2; cycle();
        wait_pct = 100;
        cycle();
        chk("midrst_outstanding", 32'(outstanding), 32'd2);
        reset_n = 1'b0; cycle(); reset_n = 1'b1;
        chk("midrst_chipselect", 32'(sdram_chipselect), 32'd0);
        chk("midrst_outstanding0", 32'(outstanding), 32'd0);
        drain();

        // Random traffic
        req_pct = 50; rd_pct = 60; wait_pct = 30; ret_pct = 50;
        for (int i = 0; i < 3000; i++) cycle();
        drain();
        chk("final_ret_q", 32'(ret_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
